sprite_cmd_sender: RTL
======================

Name: sprite_cmd_sender

Overview:
Transmit end of the sprite command bus. Software-side requests (sprite updates and frame commits) are buffered in a FIFO and encoded into the 32-bit command words decoded by the sprite display blocks (Coin, Mario, etc.).
- Update words always target the back buffer.
- A frame commit emits a buffer-swap word at the next frame boundary, then toggles the back buffer.
- Sits between the Avalon register interface and the shared writedata bus of all display blocks.

Parameters:
DEPTH, 16, request FIFO entries (power of 2, >=2)
LEVEL_W, $clog2(DEPTH)+1, width of fifo_level

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-low reset (asserted when 0), sampled on rising clk
req_valid  in  1  request present
req_ready  out  1  FIFO can accept (= !full, registered)
req_commit  in  1  1 = frame-commit marker; other req_* fields ignored
req_comp_id  in  6  component ID -> word[31:26]
req_child  in  5  child index -> word[25:21]
req_type  in  3  data type -> word[16:14]
req_data  in  13  message data {vis, flip, payload[10:0]} -> word[12:0]
frame_end  in  1  one-cycle pulse at end of visible frame (vblank start)
writedata  out  32  command word to display blocks
wr_strobe  out  1  high in the single cycle a non-NOP word is driven
busy  out  1  FIFO non-empty or FSM not IDLE
swap_pending  out  1  FSM in WAIT_FRAME
back_buffer  out  1  buffer index currently targeted by updates
fifo_level  out  LEVEL_W  entries held

Behaviour:
- Word layout: [31:26] comp_id, [25:21] child, [20:17] control, [16:14] type, [13] buffer select, [12:0] data.
- Control codes: NOP=4'h0, UPDATE=4'h1, SWAP=4'hF.
- Idle word is 32'h0 (NOP). Display blocks decode every cycle, so every non-NOP word is held for exactly one cycle; writedata returns to 0 on the next edge unless another word follows.
- Reset (reset==0 at an edge):
  - FIFO flushed; state=IDLE.
  - writedata=0, wr_strobe=0, req_ready=1, busy=0, swap_pending=0, fifo_level=0.
  - back_buffer=1, because display blocks reset with active buffer 0.
  - Reset mid-WAIT_FRAME drops the pending swap; no word is emitted.
- Accept: at an edge with req_valid & req_ready, one entry is pushed.
  - req_ready is computed from the registered level only. When full, a simultaneous pop does not raise ready in the same cycle.
- FSM states: IDLE, WAIT_FRAME.
  - IDLE, FIFO empty: drive NOP.
  - IDLE, head is update: at the next edge, drive {comp_id, child, 4'h1, type, back_buffer, data} with wr_strobe=1, and pop. Streams one word per cycle.
  - IDLE, head is commit: go to WAIT_FRAME (no pop) and drive NOP.
  - WAIT_FRAME: frame_end sampled high at an edge while already in WAIT_FRAME causes, at the next edge:
    - drive {21'h0 with control=4'hF at [20:17], [13]=back_buffer, rest 0}, wr_strobe=1;
    - pop the commit; back_buffer toggles; return to IDLE.
    - A frame_end coinciding with the edge that enters WAIT_FRAME is not counted.
- Latency:
  - Update accepted at edge E0 into an empty FIFO appears on writedata after E1 and is valid until E2.
  - Swap appears the cycle after the counted frame_end.
- Ordering: updates behind a commit are not sent until the swap word has been emitted; FIFO order is strict.
- frame_end while IDLE is ignored (not latched).
- Pushes while in WAIT_FRAME continue until full.
- No field range checking; fields pass through verbatim (truncated to port widths).

Decomposition:
- Package sprite_cmd_pkg:
  - field bit positions and CTRL_NOP / CTRL_UPDATE / CTRL_SWAP constants;
  - typedef struct packed cmd_req_t {commit, comp_id, child, type, data} (28 bits);
  - function encode_update(cmd_req_t, logic buf) returning the 32-bit word.
- Sub-module sync_fifo (width=$bits(cmd_req_t), DEPTH, same clk/reset): show-ahead head, level, full/empty.
- The FSM and output register live in sprite_cmd_sender.

Test Plan:
1. Reset: hold reset=0 for 3 cycles with req_valid=1 -> writedata=0, wr_strobe=0, fifo_level=0, back_buffer=1, req_ready=1; nothing pushed.
2. Single update: comp_id=3, child=2, type=3'b001, data=13'h1803 -> after one edge, writedata=32'h0C427803 for exactly 1 cycle with wr_strobe=1, then 32'h0.
3. Commit: push update, then commit; pulse frame_end 10 cycles later -> update word sent first; swap_pending=1 until frame_end; next cycle writedata=32'h001E2000; back_buffer becomes 0. A second commit+frame_end gives 32'h001E0000.
4. Ordering/early frame_end: commit then update queued; frame_end pulsed while IDLE before the commit reaches the head -> no swap. The update is held until a later frame_end produces the swap word, then the update goes out with [13]=new back_buffer.
5. Backpressure: push 16 updates with a commit at the head and no frame_end -> req_ready=0 at fifo_level=16, further req_valid not accepted. After frame_end, 16 words stream on consecutive cycles with no gaps.
6. Reset mid-operation: reset=0 while swap_pending=1 with 5 entries queued -> next cycle writedata=0, fifo_level=0, back_buffer=1; a later frame_end emits nothing.

Source files
------------

// File: rtl/sprite_cmd_pkg.sv
// Shared definitions for the sprite command bus transmitter.
//   - Bit positions and widths of the 32-bit command word
//   - Control codes (NOP / UPDATE / SWAP)
//   - cmd_req_t: one buffered software request (28 bits)
//   - encode_update / encode_swap: build the words seen by the display blocks
package sprite_cmd_pkg;

    localparam int COMP_ID_W = 6;
    localparam int CHILD_W   = 5;
    localparam int CTRL_W    = 4;
    localparam int TYPE_W    = 3;
    localparam int DATA_W    = 13;

    localparam int COMP_ID_LSB = 26;
    localparam int CHILD_LSB   = 21;
    localparam int CTRL_LSB    = 17;
    localparam int TYPE_LSB    = 14;
    localparam int BUF_BIT     = 13;
    localparam int DATA_LSB    = 0;

    localparam logic [CTRL_W-1:0] CTRL_NOP    = 4'h0;
    localparam logic [CTRL_W-1:0] CTRL_UPDATE = 4'h1;
    localparam logic [CTRL_W-1:0] CTRL_SWAP   = 4'hF;

    typedef struct packed {
        logic                 commit;
        logic [COMP_ID_W-1:0] comp_id;
        logic [CHILD_W-1:0]   child;
        logic [TYPE_W-1:0]    typ;
        logic [DATA_W-1:0]    data;
    } cmd_req_t;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT_FRAME
    } state_t;

    // Update word: {comp_id, child, UPDATE, type, buffer select, data}
    function automatic logic [31:0] encode_update(cmd_req_t req, logic buf_sel);
        return {req.comp_id, req.child, CTRL_UPDATE, req.typ, buf_sel, req.data};
    endfunction

    // Swap word: only the control field and buffer select are non-zero
    function automatic logic [31:0] encode_swap(logic buf_sel);
        logic [31:0] word;
        word = 32'h0;
        word[CTRL_LSB +: CTRL_W] = CTRL_SWAP;
        word[BUF_BIT]            = buf_sel;
        return word;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO.
//   clk, reset     : clock, synchronous active-low reset
//   push/push_data : write request; ignored while full
//   pop            : consume head; ignored while empty
//   head           : current head entry, valid whenever !empty
//   level          : number of entries held (registered)
//   full/empty     : decoded from the registered level
module sync_fifo #(
    parameter int WIDTH   = 28,
    parameter int DEPTH   = 16,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic [WIDTH-1:0]   push_data,
    input  logic               pop,
    output logic [WIDTH-1:0]   head,
    output logic [LEVEL_W-1:0] level,
    output logic               full,
    output logic               empty
);

    localparam int ADDR_W = $clog2(DEPTH);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [ADDR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0] level_q, level_d;
    logic               do_push;
    logic               do_pop;

    assign full    = (level_q == LEVEL_W'(DEPTH));
    assign empty   = (level_q == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr_q];
    assign level   = level_q;

    // DEPTH is a power of two, so pointers wrap by plain overflow
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   level_d = level_q + LEVEL_W'(1);
            2'b01:   level_d = level_q - LEVEL_W'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
        end
    end

    // Storage needs no reset: entries are only read once counted in level
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/sprite_cmd_sender.sv
// Transmit end of the sprite command bus.
// Buffers sprite updates and frame commits from the register interface and
// serialises them onto the shared 32-bit writedata bus of the display blocks.
//   clk, reset                     : clock, synchronous active-low reset
//   req_valid / req_ready          : request handshake (ready = FIFO not full)
//   req_commit                     : 1 = frame-commit marker
//   req_comp_id/child/type/data    : update fields
//   frame_end                      : one-cycle pulse at vblank start
//   writedata / wr_strobe          : command word, held for exactly one cycle
//   busy, swap_pending             : status
//   back_buffer                    : buffer index targeted by updates
//   fifo_level                     : entries queued
module sprite_cmd_sender
    import sprite_cmd_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int LEVEL_W = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_commit,
    input  logic [5:0]         req_comp_id,
    input  logic [4:0]         req_child,
    input  logic [2:0]         req_type,
    input  logic [12:0]        req_data,
    input  logic               frame_end,
    output logic [31:0]        writedata,
    output logic               wr_strobe,
    output logic               busy,
    output logic               swap_pending,
    output logic               back_buffer,
    output logic [LEVEL_W-1:0] fifo_level
);

    cmd_req_t    req_in;
    cmd_req_t    head_req;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;

    state_t      state_q, state_d;
    logic [31:0] writedata_q, writedata_d;
    logic        wr_strobe_q, wr_strobe_d;
    logic        back_buffer_q, back_buffer_d;

    assign req_in.commit  = req_commit;
    assign req_in.comp_id = req_comp_id;
    assign req_in.child   = req_child;
    assign req_in.typ     = req_type;
    assign req_in.data    = req_data;

    sync_fifo #(
        .WIDTH   ($bits(cmd_req_t)),
        .DEPTH   (DEPTH),
        .LEVEL_W (LEVEL_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_valid),
        .push_data (req_in),
        .pop       (fifo_pop),
        .head      (head_req),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Ready comes from the registered level, so a pop while full does not
    // reopen the input until the following cycle.
    assign req_ready    = ~fifo_full;
    assign busy         = ~fifo_empty | (state_q != ST_IDLE);
    assign swap_pending = (state_q == ST_WAIT_FRAME);
    assign writedata    = writedata_q;
    assign wr_strobe    = wr_strobe_q;
    assign back_buffer  = back_buffer_q;

    // writedata_d defaults to NOP so every word lives for exactly one cycle
    always_comb begin
        state_d       = state_q;
        writedata_d   = 32'h0;
        wr_strobe_d   = 1'b0;
        back_buffer_d = back_buffer_q;
        fifo_pop      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    if (head_req.commit) begin
                        // Commit stays at the head until the swap goes out,
                        // which holds back every later update.
                        state_d = ST_WAIT_FRAME;
                    end else begin
                        writedata_d = encode_update(head_req, back_buffer_q);
                        wr_strobe_d = 1'b1;
                        fifo_pop    = 1'b1;
                    end
                end
            end
            ST_WAIT_FRAME: begin
                // Only a frame_end seen while already waiting counts
                if (frame_end) begin
                    writedata_d   = encode_swap(back_buffer_q);
                    wr_strobe_d   = 1'b1;
                    fifo_pop      = 1'b1;
                    back_buffer_d = ~back_buffer_q;
                    state_d       = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Display blocks come out of reset showing buffer 0, so we draw into 1
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q       <= ST_IDLE;
            writedata_q   <= 32'h0;
            wr_strobe_q   <= 1'b0;
            back_buffer_q <= 1'b1;
        end else begin
            state_q       <= state_d;
            writedata_q   <= writedata_d;
            wr_strobe_q   <= wr_strobe_d;
            back_buffer_q <= back_buffer_d;
        end
    end

endmodule
